// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with a direct-select mode and an
// auto-scanning mode for multiplexed digit/row drive.
module scan_decoder #(
  parameter int SEL_W   = 3,
  parameter int DIV     = 4,
  parameter int ACT_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   o,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam int CW    = $clog2(DIV) + 1;
  localparam logic [CW-1:0]    CNT_MAX = CW'(DIV - 1);
  localparam logic [OUT_W-1:0] O_IDLE  = {OUT_W{ACT_LOW != 0}};

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [SEL_W-1:0] idx_d;
  logic             wrap_d;
  logic [OUT_W-1:0] dec;
  logic [OUT_W-1:0] o_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      wrap  <= 1'b0;
      o     <= O_IDLE;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      wrap  <= wrap_d;
      o     <= o_d;
    end
  end

  // Output is decoded from the next index so O and IDX update on the same edge.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    wrap_d  = 1'b0;
    dec     = '0;
    o_d     = O_IDLE;

    if (!en)
      state_d = IDLE;
    else if (mode)
      state_d = SCAN;
    else
      state_d = DIRECT;

    case (state_d)
      DIRECT: begin
        idx_d = sel;
        cnt_d = '0;
      end
      SCAN: begin
        if (state == IDLE) begin
          idx_d = '0;
          cnt_d = '0;
        end else if (state == DIRECT) begin
          cnt_d = '0;
        end else if (cnt == CNT_MAX) begin
          cnt_d  = '0;
          idx_d  = idx + 1'b1;
          wrap_d = &idx;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: ;
    endcase

    if (state_d != IDLE) begin
      dec = OUT_W'(1) << idx_d;
      o_d = (ACT_LOW != 0) ? ~dec : dec;
    end
  end

endmodule
